// File: rtl/step_counter_pkg.sv
// Shared types for the step counter: count modes and bounce direction encoding.
package step_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-state function of the step counter for one enabled step.
// Takes an already clamped step s (s <= limit); flags wrap/limit/turn events.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] limit,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             step_event
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // One extra bit so count + s can never silently overflow before the compare.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] limit_ext;

    assign sum       = {1'b0, count} + {1'b0, s};
    assign limit_ext = {1'b0, limit};

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/case below can leave one unassigned and infer a latch.
        next_count = count;
        next_dir   = (mode == MODE_BOUNCE) ? dir : DIR_UP;
        step_event = 1'b0;

        if (count > limit) begin
            next_count = '0;
            next_dir   = DIR_UP;
            step_event = 1'b1;
        end else if (s != '0) begin
            case (mode)
                MODE_WRAP: begin
                    if (sum > limit_ext) begin
                        // True result lies in [0, limit], so modulo-2^WIDTH math is exact.
                        next_count = count + s - limit - ONE;
                        step_event = 1'b1;
                    end else begin
                        next_count = sum[WIDTH-1:0];
                    end
                end
                MODE_SAT: begin
                    if (sum >= limit_ext) begin
                        next_count = limit;
                        step_event = (count != limit);
                    end else begin
                        next_count = sum[WIDTH-1:0];
                    end
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (sum >= limit_ext) begin
                            next_count = limit;
                            next_dir   = DIR_DOWN;
                            step_event = 1'b1;
                        end else begin
                            next_count = sum[WIDTH-1:0];
                        end
                    end else if (count <= s) begin
                        next_count = '0;
                        next_dir   = DIR_UP;
                        step_event = 1'b1;
                    end else begin
                        next_count = count - s;
                    end
                end
                MODE_DOWN: begin
                    if (count < s) begin
                        next_count = count + limit + ONE - s;
                        step_event = 1'b1;
                    end else begin
                        next_count = count - s;
                    end
                end
                default: begin
                    next_count = count;
                end
            endcase
        end
    end

endmodule

// File: rtl/step_counter.sv
// Programmable step counter producing the waveform ROM address/phase.
// Define STEP_COUNTER_PHASE_EN to add the offset input and phase-shifted count_ph output.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] incr,
    input  logic [WIDTH-1:0] limit,
    input  mode_t            mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
`ifdef STEP_COUNTER_PHASE_EN
    ,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] count_ph
`endif
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             next_dir;
    logic             step_event;

    assign s            = (incr < limit) ? incr : limit;
    assign load_clamped = (load_val < limit) ? load_val : limit;

    step_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (count),
        .dir        (dir),
        .s          (s),
        .limit      (limit),
        .mode       (mode),
        .next_count (next_count),
        .next_dir   (next_dir),
        .step_event (step_event)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            count <= '0;
            dir   <= DIR_UP;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (en) begin
            count <= next_count;
            dir   <= next_dir;
            tc    <= step_event;
        end else begin
            tc    <= 1'b0;
        end
    end

`ifdef STEP_COUNTER_PHASE_EN
    assign count_ph = count + offset;
`endif

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: expected count/dir/tc queued per cycle, compared after each edge.
module tb_step_counter;
    import step_counter_pkg::*;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         en       = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] incr     = '0;
    logic [W-1:0] limit    = '0;
    mode_t        mode     = MODE_WRAP;
    logic [W-1:0] count;
    logic         dir;
    logic         tc;
`ifdef STEP_COUNTER_PHASE_EN
    logic [W-1:0] offset   = '0;
    logic [W-1:0] count_ph;
`endif

    typedef struct {
        logic [W-1:0] count;
        logic         dir;
        logic         tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    step_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .incr     (incr),
        .limit    (limit),
        .mode     (mode),
        .count    (count),
        .dir      (dir),
        .tc       (tc)
`ifdef STEP_COUNTER_PHASE_EN
        ,
        .offset   (offset),
        .count_ph (count_ph)
`endif
    );

    always #5 clk = ~clk;

    // Queue the expectation for the coming edge, then advance to just past it.
    task automatic step(input logic [W-1:0] c, input logic d, input logic t);
        exp_t e;
        e.count = c;
        e.dir   = d;
        e.tc    = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        en = 1'b1; load = 1'b1; load_val = 8'd50; limit = 8'd20; incr = 8'd3; mode = MODE_WRAP;
        for (int i = 0; i < 2; i++) begin
            step(8'd0, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL reset[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        rst_n = 1'b1; load = 1'b0;
        step(8'd3, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
            errors++;
            $display("FAIL reset_first_step got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                     count, dir, tc, e.count, e.dir, e.tc);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [W-1:0] ec [6] = '{8'd1, 8'd5, 8'd9, 8'd3, 8'd7, 8'd1};
        logic         et [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        mode = MODE_WRAP; limit = 8'd9; incr = 8'd4; load_val = 8'd1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load = (i == 0);
            step(ec[i], 1'b0, et[i]);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL wrap[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_sat();
        exp_t e;
        logic [W-1:0] ec [4] = '{8'd0, 8'd10, 8'd10, 8'd10};
        logic         et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        mode = MODE_SAT; limit = 8'd10; incr = 8'd200; load_val = 8'd0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load = (i == 0);
            step(ec[i], 1'b0, et[i]);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL sat[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_bounce();
        exp_t e;
        logic [W-1:0] ec [11] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd4, 8'd2, 8'd0, 8'd2, 8'd4, 8'd6, 8'd6};
        logic         ed [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         et [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        mode = MODE_BOUNCE; limit = 8'd6; incr = 8'd2; load_val = 8'd0; en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            load = (i == 0);
            en   = (i != 10);
            step(ec[i], ed[i], et[i]);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL bounce[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        load = 1'b0; en = 1'b1;
    endtask

    // Starts with dir=1 left over from the bounce test: load keeps it, the first DOWN step clears it.
    task automatic test_down_out_of_range();
        exp_t e;
        logic [W-1:0] ec [5] = '{8'd3, 8'd14, 8'd9, 8'd0, 8'd0};
        logic         ed [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         et [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        mode = MODE_DOWN; limit = 8'd15; incr = 8'd5; load_val = 8'd3; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load = (i == 0);
            if (i == 3) limit = 8'd5;
            en = (i != 4);
            step(ec[i], ed[i], et[i]);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL down[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        load = 1'b0; en = 1'b1;
    endtask

    // Load clamp, bounce turn, reset mid-bounce with load, limit==0 and incr==0 holds.
    task automatic test_collisions();
        exp_t e;
        logic [W-1:0] ec [7] = '{8'd20, 8'd20, 8'd0, 8'd0, 8'd0, 8'd4, 8'd4};
        logic         ed [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         et [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin mode = MODE_WRAP; load = 1'b1; load_val = 8'd50; limit = 8'd20; incr = 8'd3; end
                1: begin mode = MODE_BOUNCE; load = 1'b0; end
                2: begin rst_n = 1'b0; load = 1'b1; end
                3: begin rst_n = 1'b1; load = 1'b0; mode = MODE_WRAP; limit = 8'd0; incr = 8'd5; end
                4: ;
                5: begin load = 1'b1; load_val = 8'd4; limit = 8'd9; incr = 8'd0; end
                default: load = 1'b0;
            endcase
            step(ec[i], ed[i], et[i]);
            e = sb.pop_front();
            checks++;
            if ({count, dir, tc} !== {e.count, e.dir, e.tc}) begin
                errors++;
                $display("FAIL collide[%0d] got count=%0d dir=%b tc=%b want count=%0d dir=%b tc=%b",
                         i, count, dir, tc, e.count, e.dir, e.tc);
            end
        end
        load = 1'b0;
    endtask

`ifdef STEP_COUNTER_PHASE_EN
    task automatic test_phase();
        offset = 8'd200; rst_n = 1'b0; en = 1'b0; load = 1'b0;
        step(8'd0, 1'b0, 1'b0);
        void'(sb.pop_front());
        checks++;
        if (count_ph !== 8'd200) begin
            errors++;
            $display("FAIL phase_reset got count_ph=%0d want 200", count_ph);
        end
        rst_n = 1'b1; offset = 8'd250; load = 1'b1; load_val = 8'd10; limit = 8'd100;
        step(8'd10, 1'b0, 1'b0);
        void'(sb.pop_front());
        checks++;
        if (count_ph !== 8'd4) begin
            errors++;
            $display("FAIL phase_wrap got count_ph=%0d want 4", count_ph);
        end
        load = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_bounce();
        test_down_out_of_range();
        test_collisions();
`ifdef STEP_COUNTER_PHASE_EN
        test_phase();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
